// File: rtl/ysyx_23060096_lsu_pkg.sv
// Shared types for the LSU: MemOP encodings, FSM states and access-size helpers.
package ysyx_23060096_lsu_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    function automatic size_t size_of(input logic [1:0] op_sz);
        size_t sz;
        case (op_sz)
            2'b00:   sz = SZ_B;
            2'b01:   sz = SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    // Address bits below the access size are dropped so lanes stay naturally aligned.
    function automatic logic [1:0] lane_lo(input size_t sz, input logic [1:0] lo);
        logic [1:0] r;
        case (sz)
            SZ_B:    r = lo;
            SZ_H:    r = {lo[1], 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] lo);
        logic m;
        case (sz)
            SZ_H:    m = lo[0];
            SZ_W:    m = |lo;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_23060096_lsu_if.sv
// Data-memory port of the LSU: request handshake plus single-cycle response.
interface ysyx_23060096_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) ();
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [3:0]        mem_wmask;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_23060096_lsu_align.sv
// Combinational lane logic: store byte strobes/replication and load lane select/extension.
module ysyx_23060096_lsu_align
    import ysyx_23060096_lsu_pkg::*;
(
    input  size_t       st_size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    input  size_t       ld_size,
    input  logic        ld_zext,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    // Replicating the narrow datum puts it in every lane; the strobe picks the live one.
    always_comb begin
        wmask = 4'b1111;
        wdata = st_data;
        case (st_size)
            SZ_B: begin
                wmask = 4'b0001 << st_lo;
                wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                wmask = 4'b0011 << st_lo;
                wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_b = ld_raw[{ld_lo, 3'b000} +: 8];
    assign ld_h = ld_raw[{ld_lo[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = ld_raw;
        case (ld_size)
            SZ_B:    ld_data = {{24{~ld_zext & ld_b[7]}}, ld_b};
            SZ_H:    ld_data = {{16{~ld_zext & ld_h[15]}}, ld_h};
            default: ;
        endcase
    end
endmodule

// File: rtl/ysyx_23060096_lsu.sv
// Load/store unit: one access per request over a valid/ready memory port.
// Define LSU_MISALIGN_CHECK_EN to fault misaligned half/word accesses instead of truncating.
module ysyx_23060096_lsu
    import ysyx_23060096_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [2:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                busy,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    ysyx_23060096_lsu_if.master mem
);
    state_t            state;
    logic              wr_q;
    logic [2:0]        op_q;
    logic [1:0]        lo_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [3:0]        wmask_q;
    logic [XLEN-1:0]   wdata_q;

    size_t       req_size;
    size_t       ld_size;
    logic [1:0]  req_lo;
    logic        req_mis;
    logic [3:0]  st_wmask;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign req_size = size_of(req_op[1:0]);
    assign ld_size  = size_of(op_q[1:0]);
    assign req_lo   = lane_lo(req_size, req_addr[1:0]);
`ifdef LSU_MISALIGN_CHECK_EN
    assign req_mis  = misaligned(req_size, req_addr[1:0]);
`else
    assign req_mis  = 1'b0;
`endif

    ysyx_23060096_lsu_align u_align (
        .st_size (req_size),
        .st_lo   (req_lo),
        .st_data (req_wdata),
        .wmask   (st_wmask),
        .wdata   (st_wdata),
        .ld_size (ld_size),
        .ld_zext (op_q[2]),
        .ld_lo   (lo_q),
        .ld_raw  (mem.mem_rdata),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            op_q    <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wmask_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wr_q    <= req_wr;
                    op_q    <= req_op;
                    lo_q    <= req_lo;
                    rdata_q <= '0;
                    err_q   <= req_mis;
                    if (req_mis) begin
                        state   <= DONE;
                        wen_q   <= 1'b0;
                        wmask_q <= '0;
                    end else begin
                        state   <= REQ;
                        addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                        wen_q   <= req_wr;
                        wmask_q <= req_wr ? st_wmask : 4'b0000;
                        wdata_q <= req_wr ? st_wdata : '0;
                    end
                end
                REQ:  if (mem.mem_req_ready) state <= WAIT;
                // Only a response seen after the request handshake belongs to this access.
                WAIT: if (mem.mem_rsp_valid) begin
                    state   <= DONE;
                    rdata_q <= wr_q ? '0 : ld_data;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready         = (state == IDLE);
    assign busy              = (state != IDLE);
    assign rsp_valid         = (state == DONE);
    assign rsp_rdata         = rdata_q;
    assign rsp_err           = err_q;
    assign mem.mem_req_valid = (state == REQ);
    assign mem.mem_addr      = addr_q;
    assign mem.mem_wen       = wen_q;
    assign mem.mem_wmask     = wmask_q;
    assign mem.mem_wdata     = wdata_q;
endmodule

// File: tb/tb_ysyx_23060096_lsu.sv
// Randomized bench for the LSU against a transaction-level model with a random-latency memory.
module tb_ysyx_23060096_lsu;
    import ysyx_23060096_lsu_pkg::*;
`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_wr, busy, rsp_valid, rsp_err;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, rsp_rdata;

    ysyx_23060096_lsu_if #(.ADDR_W(32), .XLEN(32)) mif ();

    ysyx_23060096_lsu #(.ADDR_W(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem(mif)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    // transaction model
    bit          inflight, req_pending, awaiting, rsp_due;
    logic        cur_wr;
    logic [2:0]  cur_op;
    logic [31:0] cur_addr;
    logic [31:0] exp_addr, exp_wdm, exp_rdata;
    logic [3:0]  exp_wmask;
    logic        exp_wen, exp_err;
    // memory model
    bit          mem_busy, ready_next, use_force, spurious_en;
    int          mem_cnt, stall, force_delay;
    logic [31:0] force_rdata;
    // observations for directed checks
    logic [31:0] last_rdata, last_hs_addr, last_hs_wdata;
    logic [3:0]  last_hs_wmask;
    logic        last_err, last_hs_wen;
    int          n_rsp, n_req_cyc;
    logic [2:0]  ops [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] op);
        return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic int lane_base(input logic [2:0] op, input logic [1:0] lo);
        int n = nbytes(op);
        return (int'(lo) / n) * n;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] raw);
        int n = nbytes(op);
        longint unsigned m, v;
        m = (64'd1 << (8 * n)) - 64'd1;
        v = (64'(raw) >> (8 * lane_base(op, a[1:0]))) & m;
        if (!op[2] && v[8*n-1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] mk);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) if (mk[i]) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    // Advance the model across the coming clock edge from the inputs currently applied.
    task automatic model_edge();
        int n, b;
        longint unsigned m;
        if (rst) begin
            inflight = 0; req_pending = 0; awaiting = 0; rsp_due = 0;
        end else if (rsp_due) begin
            rsp_due = 0; inflight = 0;
        end else if (awaiting) begin
            if (mif.mem_rsp_valid) begin
                awaiting = 0; rsp_due = 1; exp_err = 0;
                exp_rdata = cur_wr ? 32'h0 : model_load(cur_op, cur_addr, mif.mem_rdata);
            end
        end else if (req_pending) begin
            if (mif.mem_req_ready) begin
                req_pending = 0; awaiting = 1; mem_busy = 1;
                mem_cnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                force_delay = -1;
            end
        end else if (!inflight && req_valid) begin
            inflight = 1; cur_wr = req_wr; cur_op = req_op; cur_addr = req_addr;
            n = nbytes(req_op); b = lane_base(req_op, req_addr[1:0]);
            m = (64'd1 << (8 * n)) - 64'd1;
            exp_addr  = {req_addr[31:2], 2'b00};
            exp_wen   = req_wr;
            exp_wmask = req_wr ? 4'(((1 << n) - 1) << b) : 4'h0;
            exp_wdm   = req_wr ? 32'((64'(req_wdata) & m) << (8 * b)) : 32'h0;
            if (MIS_EN && (int'(req_addr[1:0]) % n != 0)) begin
                rsp_due = 1; exp_err = 1; exp_rdata = 32'h0;
            end else req_pending = 1;
        end
    endtask

    task automatic compare();
        chk("busy", 32'(busy), 32'(inflight));
        chk("req_ready", 32'(req_ready), 32'(!inflight));
        chk("rsp_valid", 32'(rsp_valid), 32'(rsp_due));
        chk("mem_req_valid", 32'(mif.mem_req_valid), 32'(req_pending));
        if (rsp_valid === 1'b1) n_rsp++;
        if (mif.mem_req_valid === 1'b1) n_req_cyc++;
        if (rsp_due) begin
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            last_rdata = rsp_rdata; last_err = rsp_err;
        end
        if (req_pending) begin
            chk("mem_addr", mif.mem_addr, exp_addr);
            chk("mem_wen", 32'(mif.mem_wen), 32'(exp_wen));
            chk("mem_wmask", 32'(mif.mem_wmask), 32'(exp_wmask));
            chk("mem_wdata", mif.mem_wdata & expand(exp_wmask), exp_wdm);
            last_hs_addr = mif.mem_addr; last_hs_wen = mif.mem_wen;
            last_hs_wmask = mif.mem_wmask; last_hs_wdata = mif.mem_wdata;
        end
    endtask

    task automatic mem_drive();
        if (stall > 0) begin
            mif.mem_req_ready = 1'b0;
            stall--;
            if (stall == 0) ready_next = 1;
        end else if (ready_next) begin
            mif.mem_req_ready = 1'b1;
            ready_next = 0;
        end else mif.mem_req_ready = ($urandom_range(0, 3) != 0);
        mif.mem_rsp_valid = 1'b0;
        mif.mem_rdata = $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                mif.mem_rsp_valid = 1'b1;
                if (use_force) mif.mem_rdata = force_rdata;
                use_force = 0; mem_busy = 0;
            end else mem_cnt--;
        end else if (spurious_en && $urandom_range(0, 5) == 0) mif.mem_rsp_valid = 1'b1;
    endtask

    task automatic cycle();
        model_edge();
        @(negedge clk);
        compare();
        mem_drive();
    endtask

    task automatic issue(input logic wr, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d, input bit junk);
        int t = 0;
        while (inflight && t < 100) begin cycle(); t++; end
        chk("idle_wait", 32'(inflight), 32'h0);
        req_valid = 1'b1; req_wr = wr; req_op = op; req_addr = a; req_wdata = d;
        cycle();
        req_valid = 1'b0;
        t = 0;
        while (inflight && t < 100) begin
            if (junk && $urandom_range(0, 3) == 0) begin
                req_valid = 1'b1; req_wr = 1'($urandom); req_op = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end else req_valid = 1'b0;
            cycle();
            t++;
        end
        req_valid = 1'b0;
        chk("done_wait", 32'(inflight), 32'h0);
    endtask

    initial begin
        int t, r0;
        ops = '{MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU};
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        mif.mem_req_ready = 1'b0; mif.mem_rsp_valid = 1'b0; mif.mem_rdata = '0;
        stall = 0; force_delay = -1; use_force = 0; spurious_en = 1; n_rsp = 0; n_req_cyc = 0;
        repeat (2) cycle();
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_mem_wen", 32'(mif.mem_wen), 32'h0);
        chk("rst_mem_wmask", 32'(mif.mem_wmask), 32'h0);
        rst = 1'b0;

        chk("pin_lb", model_load(MOP_B, 32'h80000003, 32'h80FF0000), 32'hFFFFFF80);
        chk("pin_lhu", model_load(MOP_HU, 32'h80000002, 32'h80011234), 32'h00008001);

        issue(1'b1, MOP_W, 32'h80000004, 32'h11223344, 0);
        chk("sw_addr", last_hs_addr, 32'h80000004);
        chk("sw_wmask", 32'(last_hs_wmask), 32'hF);
        chk("sw_wen", 32'(last_hs_wen), 32'h1);
        chk("sw_wdata", last_hs_wdata, 32'h11223344);
        chk("sw_rdata", last_rdata, 32'h0);

        issue(1'b1, MOP_B, 32'h80000007, 32'h000000AB, 0);
        chk("sb_wmask", 32'(last_hs_wmask), 32'h8);
        chk("sb_lane3", 32'(last_hs_wdata[31:24]), 32'hAB);

        use_force = 1; force_rdata = 32'h80FF0000;
        issue(1'b0, MOP_B, 32'h80000003, 32'h0, 0);
        chk("lb", last_rdata, 32'hFFFFFF80);
        use_force = 1; force_rdata = 32'h80FF0000;
        issue(1'b0, MOP_BU, 32'h80000003, 32'h0, 0);
        chk("lbu", last_rdata, 32'h00000080);
        use_force = 1; force_rdata = 32'h80011234;
        issue(1'b0, MOP_H, 32'h80000002, 32'h0, 0);
        chk("lh", last_rdata, 32'hFFFF8001);
        use_force = 1; force_rdata = 32'h80011234;
        issue(1'b0, MOP_HU, 32'h80000002, 32'h0, 0);
        chk("lhu", last_rdata, 32'h00008001);

        // Five ready-low cycles then a forced handshake: six cycles of mem_req_valid.
        stall = 5; n_req_cyc = 0;
        issue(1'b1, MOP_H, 32'h80000012, 32'h0000BEEF, 0);
        chk("stall_req_cycles", 32'(n_req_cyc), 32'd6);

        n_req_cyc = 0;
        issue(1'b0, MOP_W, 32'h80000002, 32'h0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("mis_err", 32'(last_err), 32'h1);
        chk("mis_no_mem", 32'(n_req_cyc), 32'h0);
`else
        chk("mis_addr", last_hs_addr, 32'h80000000);
        chk("mis_err", 32'(last_err), 32'h0);
`endif

        // Reset while waiting on memory: the late response must not complete anything.
        force_delay = 4;
        req_valid = 1'b1; req_wr = 1'b0; req_op = MOP_W; req_addr = 32'h80000020;
        cycle();
        req_valid = 1'b0;
        t = 0;
        while (!awaiting && t < 50) begin cycle(); t++; end
        chk("reach_wait", 32'(awaiting), 32'h1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        r0 = n_rsp;
        repeat (8) cycle();
        chk("rst_drop", 32'(n_rsp - r0), 32'h0);
        r0 = n_rsp;
        issue(1'b1, MOP_W, 32'h80000024, 32'hCAFEF00D, 0);
        chk("post_rst_rsp", 32'(n_rsp - r0), 32'h1);

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) cycle();
            issue(1'($urandom), ops[$urandom_range(0, 4)], 32'h80000000 | ($urandom & 32'hFFFF),
                  $urandom, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
